// File: rtl/stream_demux_pkg.sv
// Shared definitions for the two-channel stream demultiplexer.
// Optional feature macro: STREAM_DEMUX_STATS_EN (per-channel transfer counters).
package stream_demux_pkg;

    // Destination channel encoding; matches the in_sel pin value.
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_e;

    // Width of the completed-transfer counters.
    localparam int CNT_W = 8;

    // One-entry slot states; the slot's valid output is this state bit.
    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    // A slot can take a new word if it is empty or is draining this cycle.
    function automatic logic slot_can_accept(input logic valid, input logic ready);
        return ~valid | ready;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready register slice. The load strobe must only be raised
// when the slot can accept (empty or draining); the parent guarantees this.
// Data is never cleared on drain, so out_data keeps its last value while empty.
module stream_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             state_q;
    logic             state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: a load always wins (covers simultaneous drain + refill).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if ((state_q == SLOT_FULL) && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot registers; reset empties the slot and zeroes the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // The state bit is exported directly as the stream valid.
    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Two-channel stream demultiplexer: each accepted input word is steered by
// in_sel into a one-entry slot for channel A or B; the channels drain
// independently. in_ready is combinational from the selected channel.
// Optional feature macro: STREAM_DEMUX_STATS_EN enables the cnt_a / cnt_b
// completed-transfer counters; without it they read 0 and stats_clr is ignored.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // Handshake rule for every stream here: a word moves on a rising edge
    // where valid and ready are both high; valid never depends on ready,
    // and a producer holding valid keeps its data stable until it moves.

    ch_e  sel_ch;
    logic load_a;
    logic load_b;
    logic in_fire;

    assign sel_ch = ch_e'(in_sel);

    // in_ready follows the selected channel's ability to take a word.
    always_comb begin
        in_ready = 1'b0;
        case (sel_ch)
            CH_A:    in_ready = slot_can_accept(a_valid, a_ready);
            CH_B:    in_ready = slot_can_accept(b_valid, b_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign in_fire = in_valid & in_ready;
    assign load_a  = in_fire & (sel_ch == CH_A);
    assign load_b  = in_fire & (sel_ch == CH_B);

    stream_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .out_valid (a_valid),
        .out_data  (a_data),
        .out_ready (a_ready)
    );

    stream_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .out_valid (b_valid),
        .out_data  (b_data),
        .out_ready (b_ready)
    );

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q;
    logic [CNT_W-1:0] cnt_b_d;

    // Counter next values: clear beats increment, increments wrap naturally.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (stats_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (a_valid && a_ready) cnt_a_d = cnt_a_q + 1'b1;
            if (b_valid && b_ready) cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    // Counter registers; held at zero throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign cnt_a            = '0;
    assign cnt_b            = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized and directed bench for stream_demux with a queue-based model:
// each channel is a FIFO of capacity one that may drain and refill in the
// same cycle.
module tb_stream_demux;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic         stats_clr;
  logic [7:0]   cnt_a;
  logic [7:0]   cnt_b;

  stream_demux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .stats_clr (stats_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] last_a;
  logic [W-1:0] last_b;
  logic [7:0]   exp_cnt_a;
  logic [7:0]   exp_cnt_b;
  logic         run_en;
  int           n_pass;
  int           n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    exp_a_q.delete();
    exp_b_q.delete();
    last_a    = '0;
    last_b    = '0;
    exp_cnt_a = '0;
    exp_cnt_b = '0;
  endtask

  // monitor: checks outputs 1 time unit after each falling edge and pops
  // the model entry for any output handshake that will occur at the next rise
  initial begin
    logic hs_a;
    logic hs_b;
    forever begin
      @(negedge clk);
      #1;
      if (run_en) begin
        hs_a = 1'b0;
        hs_b = 1'b0;
        chk("a_valid", a_valid, exp_a_q.size() != 0);
        chk("b_valid", b_valid, exp_b_q.size() != 0);
        if (exp_a_q.size() != 0) begin
          chk("a_data", a_data, exp_a_q[0]);
          if (a_ready) begin
            last_a = exp_a_q.pop_front();
            hs_a   = 1'b1;
          end
        end else begin
          chk("a_data_hold", a_data, last_a);
        end
        if (exp_b_q.size() != 0) begin
          chk("b_data", b_data, exp_b_q[0]);
          if (b_ready) begin
            last_b = exp_b_q.pop_front();
            hs_b   = 1'b1;
          end
        end else begin
          chk("b_data_hold", b_data, last_b);
        end
        chk("cnt_a", cnt_a, exp_cnt_a);
        chk("cnt_b", cnt_b, exp_cnt_b);
`ifdef STREAM_DEMUX_STATS_EN
        if (stats_clr) begin
          exp_cnt_a = '0;
          exp_cnt_b = '0;
        end else begin
          if (hs_a) exp_cnt_a = exp_cnt_a + 8'd1;
          if (hs_b) exp_cnt_b = exp_cnt_b + 8'd1;
        end
`endif
      end
    end
  end

  // driver: applies one cycle of inputs, checks in_ready against the model
  // (after the monitor has accounted for this cycle's drains) and records
  // any accepted word in the matching channel queue
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic ar, input logic br, input logic clr);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    a_ready   = ar;
    b_ready   = br;
    stats_clr = clr;
    #2;
    if (!rst_n) begin
      chk("in_ready_rst", in_ready, 1'b1);
    end else if (run_en) begin
      exp_rdy = s ? (exp_b_q.size() == 0) : (exp_a_q.size() == 0);
      chk("in_ready", in_ready, exp_rdy);
      if (v && exp_rdy) begin
        if (s) exp_b_q.push_back(d);
        else   exp_a_q.push_back(d);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_a_q.size() + exp_b_q.size()) != 0; i++)
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("drain_done", exp_a_q.size() + exp_b_q.size(), 0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    run_en   = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_valid"}, a_valid, 1'b0);
    chk({tag, "_b_valid"}, b_valid, 1'b0);
    chk({tag, "_a_data"}, a_data, '0);
    chk({tag, "_b_data"}, b_data, '0);
    chk({tag, "_cnt_a"}, cnt_a, '0);
    chk({tag, "_cnt_b"}, cnt_b, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // main sequence
  initial begin
    n_pass    = 0;
    n_total   = 0;
    run_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    in_data   = '0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    stats_clr = 1'b0;
    model_clear();

    // reset state; an input offered during reset must be dropped
    repeat (2) cycle(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("reset");
    release_reset();

    // single word to A, B stays idle
    cycle(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drain();

    // A stalled: second word refused until A drains, order kept
    cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0);
    drain();

    // A full and stalled, B still accepts and drains
    cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    drain();

    // back-to-back refill of A without a bubble
    cycle(1'b1, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drain();

    // 257 words to A (counter wrap when stats are enabled), then clear
    // during a handshake
    for (int i = 0; i < 257; i++)
      cycle(1'b1, 1'b0, W'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    drain();

    // asynchronous reset with both slots full
    cycle(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    run_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    repeat (2) cycle(1'b1, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0);
    release_reset();

    // traffic after reset
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of input and both output channels.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, WIDTH, input payload.
REQ-005 SHALL have port in_sel, input, 1, destination select: 0 = channel A, 1 = channel B.
REQ-006 SHALL have port in_valid, input, 1, input payload and in_sel are valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts the input this cycle.
REQ-008 SHALL have ports a_data (output, WIDTH), a_valid (output, 1) and a_ready (input, 1), forming the channel A output stream.
REQ-009 SHALL have ports b_data (output, WIDTH), b_valid (output, 1) and b_ready (input, 1), forming the channel B output stream.
REQ-010 SHALL have port stats_clr, input, 1, synchronous clear of transfer counters.
REQ-011 SHALL have ports cnt_a and cnt_b, output, 8 each, completed-transfer counts for channels A and B.

Function
REQ-012 Each channel SHALL hold a one-entry slot with two states: EMPTY (x_valid=0) and FULL (x_valid=1).
REQ-013 in_ready SHALL equal (~x_valid | x_ready) of the channel selected by in_sel; this path is combinational.
REQ-014 Input handshake SHALL be in_valid & in_ready; on handshake, in_data SHALL load into the selected slot, and that slot SHALL be FULL on the next cycle (1-cycle latency).
REQ-015 Output handshake SHALL be x_valid & x_ready; on handshake with no load into the same slot, the slot SHALL become EMPTY on the next cycle.
REQ-016 A simultaneous output handshake and load on the same slot SHALL leave it FULL with the new data (no bubble, no loss).
REQ-017 The unselected channel SHALL be unaffected by input activity and SHALL drain independently in the same cycle.
REQ-018 While x_valid=1 and x_ready=0, x_data SHALL hold stable.
REQ-019 in_sel SHALL be sampled only on input handshake; in_sel changes while in_valid=0 or in_ready=0 SHALL have no effect.
REQ-020 Order within each channel SHALL be preserved; no ordering SHALL be guaranteed between channels.
REQ-021 x_data SHALL retain its last value when the slot is EMPTY; no clear on drain.

Reset
REQ-022 While rst_n=0: a_valid=0, b_valid=0, a_data=0, b_data=0, cnt_a=0, cnt_b=0, immediately, without waiting for clk.
REQ-023 Reset asserted mid-transfer SHALL discard slot contents; no output handshake SHALL be counted in the reset cycle.
REQ-024 in_ready SHALL be 1 during reset, since both slots are EMPTY; an input handshake during reset SHALL be ignored.

Configuration
REQ-025 Macro STREAM_DEMUX_STATS_EN SHALL control the transfer counters.
REQ-026 With the macro defined, cnt_x SHALL increment by 1 on each channel-x output handshake, wrapping 255 -> 0.
REQ-027 With the macro defined, stats_clr=1 SHALL set both counters to 0 on the next edge; stats_clr SHALL take priority over a simultaneous increment.
REQ-028 Without the macro, ports cnt_a, cnt_b and stats_clr SHALL remain present, cnt_a and cnt_b SHALL be constant 0, stats_clr SHALL be ignored, and no counter flops SHALL be synthesized.

Structure
REQ-029 Package stream_demux_pkg SHALL hold the channel enum (CH_A=0, CH_B=1) and the counter-width constant CNT_W=8.
REQ-030 Sub-module stream_slot (one-entry valid/ready register slice, parameter WIDTH) SHALL be instantiated once per channel.

Verification
REQ-031 Reset, then send 0x5 with in_sel=0 and a_ready=1 -> a_valid=1, a_data=0x5 one cycle later, b_valid=0 throughout.
REQ-032 a_ready=0, send 0x3 to A, then 0x7 to A -> in_ready=0 for the second word; a_data holds 0x3; after a_ready=1, 0x3 then 0x7 are delivered in order.
REQ-033 A full and stalled, send 0x9 to B with b_ready=1 -> accepted; b_data=0x9 next cycle; A unchanged.
REQ-034 A FULL, a_ready=1, in_valid=1 with new data 0xC to A in the same cycle -> no bubble; a_valid stays 1; a_data=0xC next cycle.
REQ-035 With STREAM_DEMUX_STATS_EN: send 257 words to A -> cnt_a=1; pulse stats_clr during a handshake -> cnt_a=0. Without the macro -> cnt_a=cnt_b=0 always.
REQ-036 Assert rst_n=0 asynchronously while both slots are FULL -> a_valid=b_valid=0 before the next clk edge.
